worker_avs_responder: RTL and testbench

WORKER_AVS_RESPONDER -- requirements
Module: worker_avs_responder

---
 rtl/worker_avs_responder.sv | 126 ++++++++++++
 tb/tb_worker_avs_responder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/worker_avs_responder.sv
// Avalon-MM slave with a doorbell/interrupt register, ID register and scratch words.
// Reads return after a fixed RD_LAT-cycle pipeline; each accepted write costs one stall cycle.
module worker_avs_responder #(
   parameter int          RD_LAT   = 2,
   parameter logic [31:0] ID_VALUE = 32'h574B_0001
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic [27:0] avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic [3:0]  avs_byteenable,
   input  logic        avs_burstcount,
   input  logic        avs_debugaccess,
   output logic        avs_waitrequest,
   output logic [31:0] avs_readdata,
   output logic        avs_readdatavalid,
   output logic        irq
);

   localparam int LAST = RD_LAT - 1;
   localparam logic [31:0] DECODE_ERR_DATA = 32'hDEAD_BEEF;

   logic        waitreq_q;
   logic        wr_accept;
   logic        rd_accept;
   logic        dec_err;
   logic [3:0]  widx;
   logic        wr_rw;
   logic        irq_set;
   logic        irq_clr;
   logic        irq_q;
   logic        irq_d;
   logic [31:0] rdata;
   logic [31:0] rw_q  [16];
   logic        vld_q [RD_LAT];
   logic [31:0] dat_q [RD_LAT];

   // Burst length is always treated as 1; debug qualifier and byte offset carry no meaning here.
   logic unused_inputs;
   assign unused_inputs = ^{avs_burstcount, avs_debugaccess, avs_address[1:0]};

   assign widx    = avs_address[5:2];
   assign dec_err = |avs_address[27:6];

   // A simultaneous read+write is treated as a write only.
   assign wr_accept = avs_write & ~waitreq_q;
   assign rd_accept = avs_read & ~avs_write & ~waitreq_q;

   // Words 1 (IRQ_STAT) and 2 (ID) have no backing storage.
   assign wr_rw = wr_accept & ~dec_err & (widx != 4'd1) & (widx != 4'd2);

   assign irq_set = wr_accept & ~dec_err & (widx == 4'd0) & avs_byteenable[0] & avs_writedata[0];
   assign irq_clr = rd_accept & ~dec_err & (widx == 4'd1);

   always_comb begin
      irq_d = irq_q;
      if (irq_set) begin
         irq_d = 1'b1;
      end else if (irq_clr) begin
         irq_d = 1'b0;
      end
   end

   always_comb begin
      rdata = '0;
      if (dec_err) begin
         rdata = DECODE_ERR_DATA;
      end else begin
         case (widx)
            4'd1:    rdata = {31'd0, irq_q};
            4'd2:    rdata = ID_VALUE;
            default: rdata = rw_q[widx];
         endcase
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         waitreq_q <= 1'b1;
         irq_q     <= 1'b0;
      end else begin
         // Stall exactly the cycle after each accepted write; also releases the post-reset stall.
         waitreq_q <= wr_accept;
         irq_q     <= irq_d;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         for (int i = 0; i < 16; i++) begin
            rw_q[i] <= '0;
         end
      end else if (wr_rw) begin
         for (int b = 0; b < 4; b++) begin
            if (avs_byteenable[b]) begin
               rw_q[widx][8*b +: 8] <= avs_writedata[8*b +: 8];
            end
         end
      end
   end

   // Data is zeroed alongside an empty valid so the output bus reads 0 when idle.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            vld_q[i] <= 1'b0;
            dat_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= rd_accept;
         dat_q[0] <= rd_accept ? rdata : '0;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign avs_waitrequest   = waitreq_q;
   assign avs_readdatavalid = vld_q[LAST];
   assign avs_readdata      = dat_q[LAST];
   assign irq               = irq_q;

endmodule

// File: tb/tb_worker_avs_responder.sv
// Directed self-checking bench for worker_avs_responder (RD_LAT = 2).
module tb_worker_avs_responder;

   localparam int          RD_LAT = 2;
   localparam logic [31:0] ID_VAL = 32'h574B_0001;

   logic        clk_clk;
   logic        reset_reset_n;
   logic [27:0] avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  avs_byteenable;
   logic        avs_burstcount;
   logic        avs_debugaccess;
   logic        avs_waitrequest;
   logic [31:0] avs_readdata;
   logic        avs_readdatavalid;
   logic        irq;

   int passed = 0;
   int total  = 0;

   worker_avs_responder #(
      .RD_LAT   (RD_LAT),
      .ID_VALUE (ID_VAL)
   ) dut (
      .clk_clk           (clk_clk),
      .reset_reset_n     (reset_reset_n),
      .avs_address       (avs_address),
      .avs_read          (avs_read),
      .avs_write         (avs_write),
      .avs_writedata     (avs_writedata),
      .avs_byteenable    (avs_byteenable),
      .avs_burstcount    (avs_burstcount),
      .avs_debugaccess   (avs_debugaccess),
      .avs_waitrequest   (avs_waitrequest),
      .avs_readdata      (avs_readdata),
      .avs_readdatavalid (avs_readdatavalid),
      .irq               (irq)
   );

   initial clk_clk = 1'b0;
   always #5 clk_clk = ~clk_clk;

   // Leaves the bench at a falling edge where waitrequest is low.
   task automatic wait_ready();
      @(negedge clk_clk);
      for (int i = 0; i < 20 && avs_waitrequest; i++) @(negedge clk_clk);
      if (avs_waitrequest) begin
         total++;
         $display("FAIL wait_ready: waitrequest still %b after 20 cycles, required 0", avs_waitrequest);
      end
   endtask

   task automatic write_word(input logic [27:0] a, input logic [31:0] d, input logic [3:0] be);
      wait_ready();
      avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
      @(posedge clk_clk);
      #1 avs_write = 1'b0;
   endtask

   // Returns the cycle (1 = first falling edge after accept) of the first valid, or -1.
   task automatic read_word(input logic [27:0] a, output int lat, output logic [31:0] d);
      wait_ready();
      avs_address = a; avs_read = 1'b1;
      @(posedge clk_clk);
      #1 avs_read = 1'b0;
      lat = -1; d = 32'hx;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_clk);
         if (avs_readdatavalid && lat < 0) begin
            lat = k; d = avs_readdata;
         end
      end
   endtask

   task automatic test_reset();
      reset_reset_n = 1'b0;
      repeat (2) @(negedge clk_clk);
      total++;
      if ({avs_waitrequest, avs_readdatavalid, irq} !== 3'b100) begin
         $display("FAIL reset_ctrl: got wr/vld/irq=%b required 100", {avs_waitrequest, avs_readdatavalid, irq});
      end else passed++;
      total++;
      if (avs_readdata !== 32'h0) $display("FAIL reset_rdata: got %h required 0", avs_readdata);
      else passed++;
      @(posedge clk_clk);
      #1 reset_reset_n = 1'b1;
      @(negedge clk_clk);
      total++;
      if (avs_waitrequest !== 1'b1) $display("FAIL post_reset_stall: got %b required 1", avs_waitrequest);
      else passed++;
      @(negedge clk_clk);
      total++;
      if (avs_waitrequest !== 1'b0) $display("FAIL post_reset_release: got %b required 0", avs_waitrequest);
      else passed++;
   endtask

   task automatic test_byte_lanes();
      int lat; logic [31:0] d;
      write_word(28'h14, 32'h1234_5678, 4'b1111);
      write_word(28'h14, 32'hAAAA_AAAA, 4'b0101);
      read_word(28'h14, lat, d);
      total++;
      if (lat !== RD_LAT) $display("FAIL lanes_latency: got %0d required %0d", lat, RD_LAT);
      else passed++;
      total++;
      if (d !== 32'h12AA_56AA) $display("FAIL lanes_data: got %h required 12aa56aa", d);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [27:0] addrs [4];
      logic [31:0] exps  [4];
      logic        exp_v;
      logic [31:0] exp_d;
      addrs[0] = 28'h08; addrs[1] = 28'h0C; addrs[2] = 28'h40; addrs[3] = 28'h08;
      exps[0]  = ID_VAL; exps[1]  = 32'h0;  exps[2]  = 32'hDEAD_BEEF; exps[3] = ID_VAL;
      wait_ready();
      // Read i is presented here at falling edge i and accepted at the following rising edge.
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) @(negedge clk_clk);
         exp_v = (k >= RD_LAT) && (k < RD_LAT + 4);
         exp_d = exp_v ? exps[k-RD_LAT] : 32'h0;
         total++;
         if (avs_readdatavalid !== exp_v) begin
            $display("FAIL b2b_valid[%0d]: got %b required %b", k, avs_readdatavalid, exp_v);
         end else passed++;
         total++;
         if (avs_readdata !== exp_d) begin
            $display("FAIL b2b_data[%0d]: got %h required %h", k, avs_readdata, exp_d);
         end else passed++;
         if (k < 4) begin
            avs_address = addrs[k]; avs_read = 1'b1;
         end else begin
            avs_read = 1'b0;
         end
      end
   endtask

   task automatic test_write_recovery();
      wait_ready();
      avs_address = 28'h10; avs_writedata = 32'h0BAD_F00D; avs_byteenable = 4'hF; avs_write = 1'b1;
      @(posedge clk_clk);
      #1 avs_write = 1'b0; avs_read = 1'b1;
      @(negedge clk_clk);
      total++;
      if (avs_waitrequest !== 1'b1) $display("FAIL recovery_stall: got %b required 1", avs_waitrequest);
      else passed++;
      @(negedge clk_clk);
      total++;
      if (avs_waitrequest !== 1'b0) $display("FAIL recovery_release: got %b required 0", avs_waitrequest);
      else passed++;
      @(posedge clk_clk);
      #1 avs_read = 1'b0;
      @(negedge clk_clk);
      total++;
      if (avs_readdatavalid !== 1'b0) $display("FAIL recovery_early_valid: got %b required 0", avs_readdatavalid);
      else passed++;
      @(negedge clk_clk);
      total++;
      if ({avs_readdatavalid, avs_readdata} !== {1'b1, 32'h0BAD_F00D}) begin
         $display("FAIL recovery_read: got vld=%b data=%h required vld=1 data=0badf00d",
                  avs_readdatavalid, avs_readdata);
      end else passed++;
   endtask

   task automatic test_read_then_write();
      int lat; logic [31:0] d;
      wait_ready();
      avs_address = 28'h14; avs_read = 1'b1;
      @(posedge clk_clk);
      #1 avs_read = 1'b0; avs_write = 1'b1; avs_address = 28'h24;
      avs_writedata = 32'h0000_0099; avs_byteenable = 4'hF;
      @(negedge clk_clk);
      total++;
      if ({avs_waitrequest, avs_readdatavalid} !== 2'b00) begin
         $display("FAIL rtw_cycle1: got wr/vld=%b required 00", {avs_waitrequest, avs_readdatavalid});
      end else passed++;
      @(posedge clk_clk);
      #1 avs_write = 1'b0;
      @(negedge clk_clk);
      total++;
      if ({avs_waitrequest, avs_readdatavalid, avs_readdata} !== {2'b11, 32'h12AA_56AA}) begin
         $display("FAIL rtw_cycle2: got wr=%b vld=%b data=%h required wr=1 vld=1 data=12aa56aa",
                  avs_waitrequest, avs_readdatavalid, avs_readdata);
      end else passed++;
      read_word(28'h24, lat, d);
      total++;
      if (d !== 32'h0000_0099) $display("FAIL rtw_readback: got %h required 00000099", d);
      else passed++;
   endtask

   task automatic test_irq();
      int lat; logic [31:0] d;
      write_word(28'h00, 32'h0000_0001, 4'hF);
      @(negedge clk_clk);
      total++;
      if (irq !== 1'b1) $display("FAIL irq_set: got %b required 1", irq);
      else passed++;
      wait_ready();
      avs_address = 28'h04; avs_read = 1'b1;
      @(posedge clk_clk);
      #1 avs_read = 1'b0;
      @(negedge clk_clk);
      total++;
      if (irq !== 1'b0) $display("FAIL irq_clear: got %b required 0", irq);
      else passed++;
      @(negedge clk_clk);
      total++;
      if ({avs_readdatavalid, avs_readdata} !== {1'b1, 32'h1}) begin
         $display("FAIL irq_stat_first: got vld=%b data=%h required vld=1 data=00000001",
                  avs_readdatavalid, avs_readdata);
      end else passed++;
      read_word(28'h04, lat, d);
      total++;
      if (d !== 32'h0) $display("FAIL irq_stat_second: got %h required 0", d);
      else passed++;
      // Lane 0 masked: bit 0 set in data must not ring the doorbell.
      write_word(28'h00, 32'hFFFF_FF01, 4'b1110);
      @(negedge clk_clk);
      total++;
      if (irq !== 1'b0) $display("FAIL irq_masked_lane: got %b required 0", irq);
      else passed++;
      // Decode-error alias of word 0 must be discarded.
      write_word(28'h100, 32'h0000_0001, 4'hF);
      @(negedge clk_clk);
      total++;
      if (irq !== 1'b0) $display("FAIL irq_decode_err: got %b required 0", irq);
      else passed++;
      read_word(28'h00, lat, d);
      total++;
      if (d !== 32'hFFFF_FF01) $display("FAIL doorbell_value: got %h required ffffff01", d);
      else passed++;
      write_word(28'h08, 32'h0, 4'hF);
      read_word(28'h08, lat, d);
      total++;
      if (d !== ID_VAL) $display("FAIL id_readonly: got %h required %h", d, ID_VAL);
      else passed++;
   endtask

   task automatic test_rw_collision();
      int lat; logic [31:0] d; logic seen;
      wait_ready();
      avs_address = 28'h0C; avs_writedata = 32'hCAFE_F00D; avs_byteenable = 4'hF;
      avs_read = 1'b1; avs_write = 1'b1;
      @(posedge clk_clk);
      #1 avs_read = 1'b0; avs_write = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_clk);
         seen |= avs_readdatavalid;
      end
      total++;
      if (seen !== 1'b0) $display("FAIL collision_valid: got %b required 0", seen);
      else passed++;
      read_word(28'h0C, lat, d);
      total++;
      if (d !== 32'hCAFE_F00D) $display("FAIL collision_data: got %h required cafef00d", d);
      else passed++;
   endtask

   task automatic test_reset_midflight();
      int lat; logic [31:0] d; logic seen;
      write_word(28'h1C, 32'h0000_0077, 4'hF);
      wait_ready();
      avs_address = 28'h1C; avs_read = 1'b1;
      repeat (2) @(posedge clk_clk);
      #1 avs_read = 1'b0; reset_reset_n = 1'b0;
      @(negedge clk_clk);
      total++;
      if ({avs_waitrequest, avs_readdatavalid, irq} !== 3'b100) begin
         $display("FAIL midreset_ctrl: got wr/vld/irq=%b required 100", {avs_waitrequest, avs_readdatavalid, irq});
      end else passed++;
      repeat (3) @(posedge clk_clk);
      #1 reset_reset_n = 1'b1;
      seen = 1'b0;
      @(negedge clk_clk);
      seen |= avs_readdatavalid;
      total++;
      if (avs_waitrequest !== 1'b1) $display("FAIL midreset_stall: got %b required 1", avs_waitrequest);
      else passed++;
      @(negedge clk_clk);
      seen |= avs_readdatavalid;
      total++;
      if (avs_waitrequest !== 1'b0) $display("FAIL midreset_release: got %b required 0", avs_waitrequest);
      else passed++;
      repeat (3) begin
         @(negedge clk_clk);
         seen |= avs_readdatavalid;
      end
      total++;
      if (seen !== 1'b0) $display("FAIL midreset_stale_valid: got %b required 0", seen);
      else passed++;
      read_word(28'h1C, lat, d);
      total++;
      if (d !== 32'h0) $display("FAIL midreset_scratch7: got %h required 0", d);
      else passed++;
      read_word(28'h14, lat, d);
      total++;
      if (d !== 32'h0) $display("FAIL midreset_scratch5: got %h required 0", d);
      else passed++;
   endtask

   initial begin
      reset_reset_n   = 1'b0;
      avs_address     = '0;
      avs_read        = 1'b0;
      avs_write       = 1'b0;
      avs_writedata   = '0;
      avs_byteenable  = '0;
      avs_burstcount  = 1'b1;
      avs_debugaccess = 1'b0;
      test_reset();
      test_byte_lanes();
      test_back_to_back();
      test_write_recovery();
      test_read_then_write();
      test_irq();
      test_rw_collision();
      test_reset_midflight();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
